// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Bytes pushed by a producer are queued in a
//   small circular FIFO and sent one frame at a time. Each frame is one start
//   bit (low), eight data bits sent LSB first, and one stop bit (high). Every
//   bit lasts CLKS_PER_BIT clocks. After each stop bit the line is held high
//   for GAP_BITS extra bit periods, which gives the downstream receiver time
//   to return to idle before the next start bit.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit (1..255)
//   FIFO_DEPTH   : FIFO entries (power of two, >= 2)
//   GAP_BITS     : idle-high bit periods after each stop bit (1..15)
//
// Ports
//   clk           : rising-edge clock for all state
//   rst_n         : asynchronous active-low reset; aborts any frame and
//                   empties the FIFO
//   input_valid   : producer presents input_Byte this cycle
//   input_Byte    : byte to queue
//   ready         : FIFO not full; a push happens when input_valid && ready
//   output_serial : registered serial line, idle high
//   busy          : transmitter FSM is not in IDLE
//   done          : one-cycle pulse after the last clock of each stop bit
//   fifo_level    : number of occupied FIFO entries

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_BITS     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          input_valid,
    input  logic [7:0]                    input_Byte,
    output logic                          ready,
    output logic                          output_serial,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Terminal counts for the bit-period counter and the gap counter.
    localparam logic [7:0]  CLK_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [11:0] GAP_LAST = 12'(GAP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   clk_count_q, clk_count_d;
    logic [2:0]   bit_index_q, bit_index_d;
    logic [11:0]  gap_count_q, gap_count_d;
    logic [7:0]   shift_q, shift_d;
    logic         serial_q, serial_d;
    logic         done_q, done_d;

    logic [AW:0]  wptr_q, rptr_q;
    logic [7:0]   mem [FIFO_DEPTH];

    logic         full, empty, push, pop;

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart when the index bits match.
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign ready      = !full;
    assign push       = input_valid && !full;
    assign fifo_level = wptr_q - rptr_q;

    assign output_serial = serial_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    // FIFO storage. Contents need no reset: the pointers alone decide which
    // entries are valid, so clearing the pointers discards everything.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= input_Byte;
        end
    end

    // FIFO pointers. A push and a pop in the same cycle both advance, leaving
    // the level unchanged. A push while full is simply ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Next-state logic for the frame sequencer. The serial line value is
    // derived from the next state so that the registered line changes on the
    // same edge the FSM enters a new state (start bit falls on the pop edge).
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        gap_count_d = gap_count_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_d     = mem[rptr_q[AW-1:0]];
                    clk_count_d = '0;
                    bit_index_d = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (clk_count_q == CLK_LAST) begin
                    clk_count_d = '0;
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            DATA: begin
                if (clk_count_q == CLK_LAST) begin
                    clk_count_d = '0;
                    if (bit_index_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            STOP: begin
                if (clk_count_q == CLK_LAST) begin
                    clk_count_d = '0;
                    gap_count_d = '0;
                    done_d      = 1'b1;
                    state_d     = GAP;
                end else begin
                    clk_count_d = clk_count_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_count_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_count_d = gap_count_q + 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[bit_index_d];
            default: serial_d = 1'b1;
        endcase
    end

    // Sequencer state. Reset forces the line high immediately, abandoning
    // any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            gap_count_q <= '0;
            shift_q     <= '0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            gap_count_q <= gap_count_d;
            shift_q     <= shift_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

endmodule
